// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the datapath. Steps a fetch (T0-T2) /
//   execute (T3-T6) sequence, one step per clk cycle, and decodes the opcode
//   held in IR to choose the execute steps for ALU-R ops, mul/div, nop and
//   halt. Every control output is a pure decode of the state register and
//   IR_Data[31:27].
//
// Ports
//   clk, reset          : clock; synchronous active-high reset to IDLE
//   run                 : start/continue, sampled in IDLE and final steps
//   IR_Data[31:0]       : instruction register contents (opcode in [31:27])
//   PC_select .. HI_enable : datapath enables/selects
//   alu_instruction[4:0]: ALU opcode, non-zero only in T4
//   Gra/Grb/Grc, Rin, Rout : general-register operand select and direction
//   instr_done          : pulse in the last step of each instruction
//   halted              : high while in HALT
//   illegal_op          : pulse in T3 for an undefined opcode
//   state_o[3:0]        : debug view of the state register
//                         (IDLE=0, T0..T6=1..7, HALT=8)
//
// Handshake: there is no valid/ready pair here; run is a level that is only
// looked at in IDLE and in an instruction's final step, so dropping it
// mid-instruction lets the current instruction finish.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR_Data,
    output logic        PC_select,
    output logic        MAR_enable,
    output logic        PC_increment_enable,
    output logic        Z_enable,
    output logic        Z_LO_select,
    output logic        Z_HI_select,
    output logic        PC_enable,
    output logic        read,
    output logic        MDR_enable,
    output logic        MDR_select,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        LO_enable,
    output logic        HI_enable,
    output logic [4:0]  alu_instruction,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal_op,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic       is_alu, is_muldiv, is_nop, is_halt;
    logic       unused_ir;

    assign opcode    = IR_Data[31:27];
    // Register fields are consumed by the datapath, not by this decode.
    assign unused_ir = ^IR_Data[26:0];

    assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    assign is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
    assign is_nop    = (opcode == 5'b11010);
    assign is_halt   = (opcode == 5'b11011);

    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        PC_select           = 1'b0;
        MAR_enable          = 1'b0;
        PC_increment_enable = 1'b0;
        Z_enable            = 1'b0;
        Z_LO_select         = 1'b0;
        Z_HI_select         = 1'b0;
        PC_enable           = 1'b0;
        read                = 1'b0;
        MDR_enable          = 1'b0;
        MDR_select          = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        LO_enable           = 1'b0;
        HI_enable           = 1'b0;
        alu_instruction     = 5'd0;
        Gra                 = 1'b0;
        Grb                 = 1'b0;
        Grc                 = 1'b0;
        Rin                 = 1'b0;
        Rout                = 1'b0;
        instr_done          = 1'b0;
        halted              = 1'b0;
        illegal_op          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
                state_d             = S_T1;
            end
            S_T1: begin
                Z_LO_select = 1'b1;
                PC_enable   = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
                state_d     = S_T2;
            end
            S_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Grb      = 1'b1;
                    Rout     = 1'b1;
                    Y_enable = 1'b1;
                    state_d  = S_T4;
                end else if (is_muldiv) begin
                    Gra      = 1'b1;
                    Rout     = 1'b1;
                    Y_enable = 1'b1;
                    state_d  = S_T4;
                end else if (is_halt) begin
                    instr_done = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    // nop and undefined opcodes both end here.
                    illegal_op = !is_nop;
                    instr_done = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                Rout            = 1'b1;
                Z_enable        = 1'b1;
                alu_instruction = opcode;
                Grc             = is_alu;
                Grb             = is_muldiv;
                state_d         = S_T5;
            end
            S_T5: begin
                Z_LO_select = 1'b1;
                if (is_muldiv) begin
                    LO_enable = 1'b1;
                    state_d   = S_T6;
                end else begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Z_HI_select = 1'b1;
                HI_enable   = 1'b1;
                instr_done  = 1'b1;
                state_d     = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    // Packed view of every control output, LSB first:
    // 0 PC_select, 1 MAR_enable, 2 PC_increment_enable, 3 Z_enable,
    // 4 Z_LO_select, 5 Z_HI_select, 6 PC_enable, 7 read, 8 MDR_enable,
    // 9 MDR_select, 10 IR_enable, 11 Y_enable, 12 LO_enable, 13 HI_enable,
    // 14 Gra, 15 Grb, 16 Grc, 17 Rin, 18 Rout, 19 instr_done, 20 halted,
    // 21 illegal_op, 26:22 alu_instruction
    localparam int W = 27;
    localparam logic [W-1:0] C_PCSEL = 27'd1 << 0;
    localparam logic [W-1:0] C_MAR   = 27'd1 << 1;
    localparam logic [W-1:0] C_PCINC = 27'd1 << 2;
    localparam logic [W-1:0] C_ZEN   = 27'd1 << 3;
    localparam logic [W-1:0] C_ZLO   = 27'd1 << 4;
    localparam logic [W-1:0] C_ZHI   = 27'd1 << 5;
    localparam logic [W-1:0] C_PCEN  = 27'd1 << 6;
    localparam logic [W-1:0] C_READ  = 27'd1 << 7;
    localparam logic [W-1:0] C_MDREN = 27'd1 << 8;
    localparam logic [W-1:0] C_MDRSL = 27'd1 << 9;
    localparam logic [W-1:0] C_IREN  = 27'd1 << 10;
    localparam logic [W-1:0] C_YEN   = 27'd1 << 11;
    localparam logic [W-1:0] C_LOEN  = 27'd1 << 12;
    localparam logic [W-1:0] C_HIEN  = 27'd1 << 13;
    localparam logic [W-1:0] C_GRA   = 27'd1 << 14;
    localparam logic [W-1:0] C_GRB   = 27'd1 << 15;
    localparam logic [W-1:0] C_GRC   = 27'd1 << 16;
    localparam logic [W-1:0] C_RIN   = 27'd1 << 17;
    localparam logic [W-1:0] C_ROUT  = 27'd1 << 18;
    localparam logic [W-1:0] C_DONE  = 27'd1 << 19;
    localparam logic [W-1:0] C_HALT  = 27'd1 << 20;
    localparam logic [W-1:0] C_ILL   = 27'd1 << 21;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] IR_Data;
    logic PC_select, MAR_enable, PC_increment_enable, Z_enable, Z_LO_select;
    logic Z_HI_select, PC_enable, read, MDR_enable, MDR_select, IR_enable;
    logic Y_enable, LO_enable, HI_enable, Gra, Grb, Grc, Rin, Rout;
    logic instr_done, halted, illegal_op;
    logic [4:0] alu_instruction;
    logic [3:0] state_o;
    logic [W-1:0] dut_word;

    int checks   = 0;
    int failures = 0;

    control_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .IR_Data             (IR_Data),
        .PC_select           (PC_select),
        .MAR_enable          (MAR_enable),
        .PC_increment_enable (PC_increment_enable),
        .Z_enable            (Z_enable),
        .Z_LO_select         (Z_LO_select),
        .Z_HI_select         (Z_HI_select),
        .PC_enable           (PC_enable),
        .read                (read),
        .MDR_enable          (MDR_enable),
        .MDR_select          (MDR_select),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .LO_enable           (LO_enable),
        .HI_enable           (HI_enable),
        .alu_instruction     (alu_instruction),
        .Gra                 (Gra),
        .Grb                 (Grb),
        .Grc                 (Grc),
        .Rin                 (Rin),
        .Rout                (Rout),
        .instr_done          (instr_done),
        .halted              (halted),
        .illegal_op          (illegal_op),
        .state_o             (state_o)
    );

    assign dut_word = {alu_instruction, illegal_op, halted, instr_done, Rout,
                       Rin, Grc, Grb, Gra, HI_enable, LO_enable, Y_enable,
                       IR_enable, MDR_select, MDR_enable, read, PC_enable,
                       Z_HI_select, Z_LO_select, Z_enable, PC_increment_enable,
                       MAR_enable, PC_select};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The model holds the list of control words still to be issued for the
    // current instruction. Fetch words are queued when an instruction starts;
    // execute words are appended once IR is known (at the end of T2).
    logic [W-1:0] exp_q[$];
    bit           m_valid = 0;
    bit           m_halt  = 0;
    bit           m_halt_pending = 0;
    int           m_step  = 0;

    task automatic load_fetch();
        exp_q.push_back(C_PCSEL | C_MAR | C_PCINC | C_ZEN);
        exp_q.push_back(C_ZLO | C_PCEN | C_READ | C_MDREN);
        exp_q.push_back(C_MDRSL | C_IREN);
        m_step = 0;
        m_halt_pending = 0;
    endtask

    task automatic load_exec(input logic [4:0] op);
        logic [W-1:0] alu_w;
        alu_w = {op, 22'd0};
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(C_GRB | C_ROUT | C_YEN);
            exp_q.push_back(C_GRC | C_ROUT | C_ZEN | alu_w);
            exp_q.push_back(C_ZLO | C_GRA | C_RIN | C_DONE);
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(C_GRA | C_ROUT | C_YEN);
            exp_q.push_back(C_GRB | C_ROUT | C_ZEN | alu_w);
            exp_q.push_back(C_ZLO | C_LOEN);
            exp_q.push_back(C_ZHI | C_HIEN | C_DONE);
        end else if (op == 5'd26) begin
            exp_q.push_back(C_DONE);
        end else if (op == 5'd27) begin
            exp_q.push_back(C_DONE);
            m_halt_pending = 1;
        end else begin
            exp_q.push_back(C_ILL | C_DONE);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_halt  = 0;
            m_halt_pending = 0;
            m_step  = 0;
            m_valid = 1;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (exp_q.size() == 0) begin
            if (run) load_fetch();
        end else begin
            void'(exp_q.pop_front());
            m_step++;
            if (m_step == 3) load_exec(IR_Data[31:27]);
            if (exp_q.size() == 0) begin
                if (m_halt_pending) m_halt = 1;
                else if (run) load_fetch();
            end
        end
    end

    function automatic logic [W-1:0] model_word();
        if (m_halt) return C_HALT;
        if (exp_q.size() == 0) return '0;
        return exp_q[0];
    endfunction

    function automatic logic [3:0] model_state();
        if (m_halt) return 4'd8;
        if (exp_q.size() == 0) return 4'd0;
        return 4'(1 + m_step);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_outputs", dut_word, model_word());
            check("model_state", W'(state_o), W'(model_state()));
        end
    end

    // ---------------- driver ----------------
    // Inputs change 2 time units after the rising edge; checks made right
    // after step() see the outputs of the state just entered.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [4:0] ops  [8] = '{5'b00100, 5'b00101, 5'b00111, 5'b01011,
                             5'b10000, 5'b11010, 5'b00000, 5'b11100};
    int         lats [8] = '{6, 6, 6, 6, 7, 4, 4, 4};

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        IR_Data = 32'd0;
        step_n(2);
        check("reset_outputs", dut_word, 27'd0);
        check("reset_state", W'(state_o), 27'd0);
        reset = 1'b0;
        step();
        check("idle_hold", W'(state_o), 27'd0);

        // mul R6,R7, run dropped mid-instruction
        run     = 1'b1;
        IR_Data = 32'h7B380000;
        step();
        check("t0_word", dut_word, 27'h000000F);
        check("t0_state", W'(state_o), 27'd1);
        step();
        check("t1_word", dut_word, 27'h00001D0);
        step_n(2);
        check("mul_t3", dut_word, 27'h0044800);
        step();
        check("mul_t4", dut_word, 27'h3C48008);
        run = 1'b0;
        step();
        check("mul_t5", dut_word, 27'h0001010);
        step();
        check("mul_t6", dut_word, 27'h0082020);
        step();
        check("mul_to_idle", W'(state_o), 27'd0);

        // add R1,R2,R3 followed back-to-back by an illegal opcode
        IR_Data = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        run     = 1'b1;
        step_n(4);
        check("add_t3", dut_word, 27'h0048800);
        step();
        check("add_t4", dut_word, 27'h0C50008);
        step();
        check("add_t5", dut_word, 27'h00A4010);
        step();
        check("add_next_t0", W'(state_o), 27'd1);
        IR_Data = 32'hF8000000;
        step_n(3);
        check("ill_t3", dut_word, 27'h0280000);
        run = 1'b0;
        step();
        check("ill_to_idle", W'(state_o), 27'd0);

        // back-to-back latency table
        run = 1'b1;
        step();
        foreach (ops[k]) begin
            IR_Data = {ops[k], 27'd0};
            step_n(lats[k]);
            check("latency_next_t0", W'(state_o), 27'd1);
        end

        // halt holds against run, only reset leaves
        IR_Data = {5'b11011, 27'd0};
        step_n(4);
        check("halt_word", dut_word, 27'h0100000);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold", W'(halted), 27'd1);
        end
        reset = 1'b1;
        step();
        check("halt_reset_word", dut_word, 27'd0);
        check("halt_reset_state", W'(state_o), 27'd0);
        reset = 1'b0;

        // reset during T4 of mul
        IR_Data = 32'h7B380000;
        step();
        step_n(4);
        check("mul_t4_again", W'(state_o), 27'd5);
        reset = 1'b1;
        step();
        check("midreset_word", dut_word, 27'd0);
        check("midreset_state", W'(state_o), 27'd0);
        reset = 1'b0;
        run   = 1'b0;
        step_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
